// File: rtl/led_pattern_decoder_if.sv
// Bus bundle between an LED frame source and the pattern decoder.
//   clear       : synchronous restart of the decoder
//   led_in      : observed 8-bit LED frame
//   pattern_id  : decoded pattern family (0 NONE .. 6 BOUNCE)
//   locked      : pattern_id / step_period are valid
//   step_period : cycles per frame of the locked pattern
//   step_valid  : one-cycle pulse per classified transition
//   static_det  : frame has not changed for the full counter range
// master drives frames (source / bench), slave is the decoder.
interface led_pattern_decoder_if #(
  parameter int unsigned PERIOD_W = 24
);
  logic                clear;
  logic [7:0]          led_in;
  logic [2:0]          pattern_id;
  logic                locked;
  logic [PERIOD_W-1:0] step_period;
  logic                step_valid;
  logic                static_det;

  modport master (
    output clear, led_in,
    input  pattern_id, locked, step_period, step_valid, static_det
  );

  modport slave (
    input  clear, led_in,
    output pattern_id, locked, step_period, step_valid, static_det
  );
endinterface

// File: rtl/led_pattern_decoder.sv
// LED pattern decoder: watches an 8-bit LED bus, classifies every frame
// transition (INV/SHL/SHR/INC/DEC), and locks onto a pattern family and its
// step period once enough consecutive transitions agree.
// Ports:
//   clk_10MHz : system clock (same domain as the LED source, no synchronizer)
//   rst       : asynchronous active-high reset
//   bus       : led_pattern_decoder_if.slave (clear, led_in in; results out)
// All outputs are registered and lag a led_in change by two clocks.
module led_pattern_decoder #(
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned LOCK_COUNT = 4
) (
  input logic                  clk_10MHz,
  input logic                  rst,
  led_pattern_decoder_if.slave bus
);

  // Lock threshold held in a 4-bit match counter; legal range is 2..15.
  localparam int unsigned MATCH_W  = 4;
  localparam int unsigned LOCK_CLP = (LOCK_COUNT < 2)  ? 2 :
                                     (LOCK_COUNT > 15) ? 15 : LOCK_COUNT;
  localparam logic [MATCH_W-1:0]  LOCK_M  = MATCH_W'(LOCK_CLP);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_TRACK,
    ST_LOCKED
  } state_e;

  typedef enum logic [2:0] {
    PAT_NONE   = 3'd0,
    PAT_SHL    = 3'd1,
    PAT_SHR    = 3'd2,
    PAT_INC    = 3'd3,
    PAT_DEC    = 3'd4,
    PAT_INV    = 3'd5,
    PAT_BOUNCE = 3'd6,
    PAT_RSVD   = 3'd7
  } pat_e;

  // Transition class, first match wins; PAT_NONE stands for OTHER.
  function automatic pat_e classify(input logic [7:0] p, input logic [7:0] c);
    logic [7:0] p_inc;
    logic [7:0] p_dec;
    p_inc = p + 8'd1;
    p_dec = p - 8'd1;
    if (c == ~p)                     return PAT_INV;
    else if (c == {p[6:0], p[7]})    return PAT_SHL;
    else if (c == {p[0], p[7:1]})    return PAT_SHR;
    else if (c == p_inc)             return PAT_INC;
    else if (c == p_dec)             return PAT_DEC;
    else                             return PAT_NONE;
  endfunction

  // Registered state
  state_e              state_q,  state_nxt;
  logic [7:0]          cur_q,    cur_nxt;
  logic [7:0]          prev_q,   prev_nxt;
  logic [PERIOD_W-1:0] cnt_q,    cnt_nxt;
  pat_e                cand_q,   cand_nxt;
  logic [PERIOD_W-1:0] per_q,    per_nxt;
  logic [MATCH_W-1:0]  match_q,  match_nxt;
  pat_e                pid_q,    pid_nxt;
  logic                lock_q,   lock_nxt;
  logic [PERIOD_W-1:0] sp_q,     sp_nxt;
  logic                sv_q,     sv_nxt;
  logic                stat_q,   stat_nxt;

  // Combinational helpers
  logic                change_c;
  pat_e                cls_c;
  logic [PERIOD_W-1:0] period_c;
  logic                opposite_c;
  logic                consistent_c;
  logic [MATCH_W-1:0]  match_inc_c;

  assign change_c = (cur_q != prev_q);
  assign cls_c    = classify(prev_q, cur_q);
  assign period_c = cnt_q + PERIOD_W'(1);

  // A shift in the opposite direction of a shift candidate means bounce.
  assign opposite_c = ((cand_q == PAT_SHL) && (cls_c == PAT_SHR)) ||
                      ((cand_q == PAT_SHR) && (cls_c == PAT_SHL));

  assign consistent_c = (period_c == per_q) && (cls_c != PAT_NONE) &&
                        (cand_q != PAT_NONE) &&
                        ((cls_c == cand_q) || opposite_c ||
                         ((cand_q == PAT_BOUNCE) &&
                          ((cls_c == PAT_SHL) || (cls_c == PAT_SHR))));

  assign match_inc_c = (match_q >= LOCK_M) ? LOCK_M : match_q + MATCH_W'(1);

  // State register
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= 8'h00;
      prev_q  <= 8'h00;
      cnt_q   <= '0;
      cand_q  <= PAT_NONE;
      per_q   <= '0;
      match_q <= '0;
      pid_q   <= PAT_NONE;
      lock_q  <= 1'b0;
      sp_q    <= '0;
      sv_q    <= 1'b0;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cur_q   <= cur_nxt;
      prev_q  <= prev_nxt;
      cnt_q   <= cnt_nxt;
      cand_q  <= cand_nxt;
      per_q   <= per_nxt;
      match_q <= match_nxt;
      pid_q   <= pid_nxt;
      lock_q  <= lock_nxt;
      sp_q    <= sp_nxt;
      sv_q    <= sv_nxt;
      stat_q  <= stat_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt = state_q;
    cur_nxt   = bus.led_in;
    prev_nxt  = prev_q;
    cnt_nxt   = cnt_q;
    cand_nxt  = cand_q;
    per_nxt   = per_q;
    match_nxt = match_q;
    pid_nxt   = pid_q;
    lock_nxt  = lock_q;
    sp_nxt    = sp_q;
    sv_nxt    = 1'b0;
    stat_nxt  = stat_q;

    if (bus.clear) begin
      // Synchronous restart to the reset image.
      state_nxt = ST_IDLE;
      cur_nxt   = 8'h00;
      prev_nxt  = 8'h00;
      cnt_nxt   = '0;
      cand_nxt  = PAT_NONE;
      per_nxt   = '0;
      match_nxt = '0;
      pid_nxt   = PAT_NONE;
      lock_nxt  = 1'b0;
      sp_nxt    = '0;
      stat_nxt  = 1'b0;
    end else if (change_c) begin
      prev_nxt = cur_q;
      cnt_nxt  = '0;
      stat_nxt = 1'b0;
      case (state_q)
        // Interval since reset/static is not a real period: just arm.
        ST_IDLE: begin
          state_nxt = ST_FIRST;
        end
        ST_FIRST: begin
          sv_nxt    = 1'b1;
          cand_nxt  = cls_c;
          per_nxt   = period_c;
          match_nxt = MATCH_W'(1);
          state_nxt = ST_TRACK;
        end
        default: begin
          sv_nxt = 1'b1;
          if (consistent_c) begin
            cand_nxt  = opposite_c ? PAT_BOUNCE : cand_q;
            match_nxt = match_inc_c;
            if (match_inc_c == LOCK_M) begin
              state_nxt = ST_LOCKED;
              lock_nxt  = 1'b1;
              pid_nxt   = opposite_c ? PAT_BOUNCE : cand_q;
              sp_nxt    = per_q;
            end
          end else begin
            // Restart tracking from this transition; step_period keeps
            // the last locked value.
            cand_nxt  = cls_c;
            per_nxt   = period_c;
            match_nxt = MATCH_W'(1);
            lock_nxt  = 1'b0;
            pid_nxt   = PAT_NONE;
            state_nxt = ST_TRACK;
          end
        end
      endcase
    end else begin
      // Saturating period counter; reaching the top means the bus is static.
      cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_W'(1);
      if (cnt_nxt == CNT_MAX) begin
        stat_nxt  = 1'b1;
        lock_nxt  = 1'b0;
        pid_nxt   = PAT_NONE;
        cand_nxt  = PAT_NONE;
        match_nxt = '0;
        state_nxt = ST_IDLE;
      end
    end
  end

  assign bus.pattern_id  = pid_q;
  assign bus.locked      = lock_q;
  assign bus.step_period = sp_q;
  assign bus.step_valid  = sv_q;
  assign bus.static_det  = stat_q;

endmodule

// File: doc/led_pattern_decoder.md
Name: led_pattern_decoder

Overview:
- Receive-side counterpart of the multi-pattern LED sequencer: watches an 8-bit LED bus and identifies which pattern family is playing and its step period in clock cycles.
- Used on-chip as a loopback self-test monitor, with the sequencer's led_out fed to led_in, and as a generic frame classifier for the uo_out bus.
- Same clock domain as the sequencer, so no input synchronizer.

Parameters:
- PERIOD_W, 24, width of the step-period counter and of step_period.
- LOCK_COUNT, 4, consecutive consistent transitions required to assert locked (legal range 2..15).

Ports:
- clk_10MHz  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous restart, equivalent to reset except it is not asynchronous.
- led_in  in  8  observed LED frame.
- pattern_id  out  3  0 NONE, 1 SHL, 2 SHR, 3 INC, 4 DEC, 5 INV, 6 BOUNCE, 7 reserved (never driven).
- locked  out  1  pattern_id and step_period are valid.
- step_period  out  PERIOD_W  cycles per frame of the locked pattern.
- step_valid  out  1  one-cycle pulse per classified transition.
- static_det  out  1  no frame change for 2^PERIOD_W-1 cycles.

Behaviour:
- Input path and latency
  - led_in is registered into cur; prev holds the last distinct frame.
  - change = (cur != prev).
  - All state and outputs update on the edge after change is seen: outputs lag a led_in change by 2 clocks.
- Reset / clear values: cur=prev=0x00, cnt=0, state=IDLE, cand=NONE, match_cnt=0, and all outputs 0.
- Period counter
  - On change, cnt<=0; otherwise cnt increments, saturating at 2^PERIOD_W-1.
  - Measured period of a change = cnt+1, so a frame that changes every cycle has period 1.
- Transition class (prev->cur), first match wins in this priority:
  - INV: cur==~prev.
  - SHL: cur=={prev[6:0],prev[7]}.
  - SHR: cur=={prev[0],prev[7:1]}.
  - INC: cur==prev+1 mod 256.
  - DEC: cur==prev-1 mod 256.
  - Otherwise OTHER.
- FSM states:
  - IDLE: on change, prev<=cur and go to FIRST. No classification and no step_valid, because the interval from reset is not a real period.
  - FIRST: on change, classify; cand<=class (NONE if OTHER), per<=period, match_cnt<=1, step_valid=1, go to TRACK.
  - TRACK / LOCKED: on change, step_valid=1 and compute consistency.
    - Consistent if period==per AND one of: class==cand; cand∈{SHL,SHR} and class is the opposite shift, in which case cand<=BOUNCE; cand==BOUNCE and class∈{SHL,SHR}.
    - OTHER is never consistent, and cand==NONE never matches.
    - Consistent: match_cnt saturates at LOCK_COUNT. When match_cnt reaches LOCK_COUNT, go to LOCKED: locked=1, pattern_id=cand, step_period=per.
    - Inconsistent: cand<=class, per<=period, match_cnt<=1, locked<=0, pattern_id<=0, step_period holds its last value, go to TRACK.
- Static detection
  - In any state, when cnt reaches saturation: static_det=1, locked=0, pattern_id=0, and go to IDLE.
  - static_det clears on the next change.
- Simultaneous events: rst dominates clear; clear dominates change in the same cycle.
- prev<=cur on every change, in every state.

Test Plan:
- Rotate-left walking one 0x01,0x02,0x04,... each held 10 cycles, LOCK_COUNT=4 -> step_valid from the 2nd change; locked=1, pattern_id=1, step_period=10 two clocks after the 5th change.
- Binary up-count from 0x10, held 3 cycles each -> pattern_id=3, step_period=3. Then inject 0x99 -> locked=0 and pattern_id=0 within 2 clocks.
- Bounce 0x01->0x02->0x04->0x08->0x04->0x02, 7 cycles each -> locks as 6 (BOUNCE) and stays locked through each direction reversal.
- 0x55/0xAA alternation every cycle -> classified INV (not SHL), pattern_id=5, step_period=1.
- Held frame with PERIOD_W=8 -> static_det=1 after 255 idle cycles. Next change returns to FIRST with no step_valid.
- Period jitter (10,10,11) -> match_cnt restarts and no lock. Assert rst mid-LOCKED -> all outputs 0 asynchronously; clear behaves the same on the next edge.
